// File: rtl/man_coder_pkg.sv
// Shared types and helpers for the multi-lane Manchester encoder.
// Half-level pairs are packed as {first, second}.
package man_coder_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FIRST_HALF  = 2'd1,
        SECOND_HALF = 2'd2
    } lane_state_t;

    localparam logic MODE_THOMAS = 1'b0;
    localparam logic MODE_IEEE   = 1'b1;

    function automatic logic [1:0] half_levels(input logic data_bit, input logic mode);
        if (mode == MODE_IEEE)
            return data_bit ? 2'b01 : 2'b10;
        return data_bit ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/man_coder_lane.sv
// One Manchester encoder lane: valid/ready word intake, half-bit timing and
// shift-out.  A word accepted on the last cycle of a frame starts with no gap.
module man_coder_lane
    import man_coder_pkg::*;
#(
    parameter int FRAME_BITS    = 8,
    parameter int HALF_BIT_CLKS = 3,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit IDLE_LEVEL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FRAME_BITS-1:0] in_data,
    input  logic                  mode_ieee,
    output logic                  tx_line,
    output logic                  tx_active,
    output logic                  frame_done
);

    localparam int PW = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    // Handshake: a word moves when in_valid and in_ready are both high at a
    // rising clk edge; in_ready is a decode of registered state only.
    lane_state_t           state;
    logic [PW-1:0]         ph_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  mode;

    logic                  last_half;
    logic                  frame_end;
    logic                  accept;
    logic [FRAME_BITS-1:0] shifted;
    logic [1:0]            lv_in;
    logic [1:0]            lv_cur;
    logic [1:0]            lv_nxt;

    function automatic logic lead_bit(input logic [FRAME_BITS-1:0] w);
        return MSB_FIRST ? w[FRAME_BITS-1] : w[0];
    endfunction

    assign last_half  = (ph_cnt == PW'(HALF_BIT_CLKS - 1));
    assign frame_end  = (state == SECOND_HALF) && last_half && (bit_cnt == BW'(FRAME_BITS - 1));
    assign in_ready   = (state == IDLE) || frame_end;
    assign frame_done = frame_end;
    assign accept     = in_valid && in_ready;
    assign shifted    = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    assign lv_in      = half_levels(lead_bit(in_data), mode_ieee);
    assign lv_cur     = half_levels(lead_bit(shreg), mode);
    assign lv_nxt     = half_levels(lead_bit(shifted), mode);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            mode      <= MODE_THOMAS;
            tx_line   <= IDLE_LEVEL;
            tx_active <= 1'b0;
        end else if (accept) begin
            state     <= FIRST_HALF;
            ph_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= in_data;
            mode      <= mode_ieee;
            tx_line   <= lv_in[1];
            tx_active <= 1'b1;
        end else begin
            unique case (state)
                FIRST_HALF: begin
                    if (last_half) begin
                        state   <= SECOND_HALF;
                        ph_cnt  <= '0;
                        tx_line <= lv_cur[0];
                    end else begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end
                end
                SECOND_HALF: begin
                    if (!last_half) begin
                        ph_cnt <= ph_cnt + PW'(1);
                    end else if (!frame_end) begin
                        state   <= FIRST_HALF;
                        ph_cnt  <= '0;
                        bit_cnt <= bit_cnt + BW'(1);
                        shreg   <= shifted;
                        tx_line <= lv_nxt[1];
                    end else begin
                        // Frame over and nothing queued behind it.
                        state     <= IDLE;
                        ph_cnt    <= '0;
                        tx_line   <= IDLE_LEVEL;
                        tx_active <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/man_coder_multi.sv
// Multi-lane Manchester encoder top: slices the packed word bus per lane and
// packs the per-lane outputs back into vectors.
module man_coder_multi
    import man_coder_pkg::*;
#(
    parameter int N_CH          = 2,
    parameter int FRAME_BITS    = 8,
    parameter int HALF_BIT_CLKS = 3,
    parameter bit MSB_FIRST     = 1'b1,
    parameter bit IDLE_LEVEL    = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_CH-1:0]            in_valid,
    output logic [N_CH-1:0]            in_ready,
    input  logic [N_CH*FRAME_BITS-1:0] in_data,
    input  logic [N_CH-1:0]            mode_ieee,
    output logic [N_CH-1:0]            tx_line,
    output logic [N_CH-1:0]            tx_active,
    output logic [N_CH-1:0]            frame_done
);

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        man_coder_lane #(
            .FRAME_BITS    (FRAME_BITS),
            .HALF_BIT_CLKS (HALF_BIT_CLKS),
            .MSB_FIRST     (MSB_FIRST),
            .IDLE_LEVEL    (IDLE_LEVEL)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid[i]),
            .in_ready   (in_ready[i]),
            .in_data    (in_data[i*FRAME_BITS +: FRAME_BITS]),
            .mode_ieee  (mode_ieee[i]),
            .tx_line    (tx_line[i]),
            .tx_active  (tx_active[i]),
            .frame_done (frame_done[i])
        );
    end

endmodule

// File: tb/tb_man_coder_multi.sv
// Directed bench for man_coder_multi with 2 lanes, 4-bit frames, 3-clk half bits.
// Waveforms are gathered MSB = first cycle after the accept edge.
module tb_man_coder_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in_valid;
    logic [1:0] in_ready;
    logic [7:0] in_data;
    logic [1:0] mode_ieee;
    logic [1:0] tx_line;
    logic [1:0] tx_active;
    logic [1:0] frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    man_coder_multi #(
        .N_CH          (2),
        .FRAME_BITS    (4),
        .HALF_BIT_CLKS (3),
        .MSB_FIRST     (1'b1),
        .IDLE_LEVEL    (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mode_ieee  (mode_ieee),
        .tx_line    (tx_line),
        .tx_active  (tx_active),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [3:0]  word;
        logic        mode;
        logic [23:0] wave;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Present a word on one lane for exactly one accept edge.
    task automatic send(input int lane, input logic [3:0] word, input logic mode);
        @(negedge clk);
        check("ready_before_send", 48'(in_ready[lane]), 48'd1);
        in_valid[lane]         = 1'b1;
        in_data[lane*4 +: 4]   = word;
        mode_ieee[lane]        = mode;
        @(posedge clk);
        #1;
        in_valid[lane] = 1'b0;
    endtask

    task automatic capture(input int lane, input int ncyc, input int drop_at,
                           output logic [47:0] w, output logic [47:0] a,
                           output logic [47:0] d, output logic [47:0] r);
        w = '0; a = '0; d = '0; r = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            w = {w[46:0], tx_line[lane]};
            a = {a[46:0], tx_active[lane]};
            d = {d[46:0], frame_done[lane]};
            r = {r[46:0], in_ready[lane]};
            if (k == drop_at) in_valid[lane] = 1'b0;
        end
    endtask

    task automatic check_idle(input string name, input int lane);
        @(negedge clk);
        check(name, {45'd0, tx_line[lane], tx_active[lane], in_ready[lane]}, 48'b001);
    endtask

    task automatic run_frame(input int lane, input logic [3:0] word, input logic mode,
                             input logic [23:0] exp_wave);
        logic [47:0] w, a, d, r;
        send(lane, word, mode);
        capture(lane, 24, 0, w, a, d, r);
        check("frame_wave", w, {24'd0, exp_wave});
        check("frame_active", a, {24'd0, 24'hFFFFFF});
        check("frame_done", d, 48'd1);
        check("frame_ready", r, 48'd1);
        check_idle("frame_tail_idle", lane);
    endtask

    initial begin
        logic [47:0] w, a, d, r;
        logic [47:0] w0, d0, w1, d1;
        logic        bad_line, bad_ready, bad_done, bad_act;

        vecs[0] = '{0, 4'b1010, 1'b0, 24'b111000000111111000000111};
        vecs[1] = '{0, 4'b1010, 1'b1, 24'b000111111000000111111000};
        vecs[2] = '{1, 4'b0001, 1'b0, 24'b000111000111000111111000};
        vecs[3] = '{1, 4'b1100, 1'b1, 24'b000111000111111000111000};
        vecs[4] = '{0, 4'b1111, 1'b0, 24'b111000111000111000111000};
        vecs[5] = '{1, 4'b0000, 1'b1, 24'b111000111000111000111000};
        vecs[6] = '{0, 4'b0110, 1'b0, 24'b000111111000111000000111};
        vecs[7] = '{1, 4'b1000, 1'b1, 24'b000111111000111000111000};

        // Clock/reset
        reset     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        mode_ieee = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("reset_outputs", {40'd0, tx_line, tx_active, frame_done, in_ready}, 48'b00000011);

        // Single frames from the table
        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].lane, vecs[i].word, vecs[i].mode, vecs[i].wave);

        // Back-to-back on lane1: valid held across the frame boundary
        @(negedge clk);
        in_valid[1]  = 1'b1;
        in_data[7:4] = 4'b1111;
        mode_ieee[1] = 1'b0;
        @(posedge clk);
        #1 in_data[7:4] = 4'b0000;
        capture(1, 48, 25, w, a, d, r);
        check("b2b_wave", w, {24'b111000111000111000111000, 24'b000111000111000111000111});
        check("b2b_active", a, {48{1'b1}});
        check("b2b_done", d, (48'd1 << 24) | 48'd1);
        check("b2b_ready", r, (48'd1 << 24) | 48'd1);
        check_idle("b2b_tail_idle", 1);

        // Independent lanes, lane1 five cycles behind, inputs toggled mid-frame
        @(negedge clk);
        in_valid[0]  = 1'b1;
        in_data[3:0] = 4'b0001;
        mode_ieee[0] = 1'b0;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        w0 = '0; d0 = '0; w1 = '0; d1 = '0;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            w0 = {w0[46:0], tx_line[0]};
            d0 = {d0[46:0], frame_done[0]};
            w1 = {w1[46:0], tx_line[1]};
            d1 = {d1[46:0], frame_done[1]};
            if (k == 3) begin
                in_data[3:0] = 4'b1110;
                mode_ieee[0] = 1'b1;
            end
            if (k == 5) begin
                in_valid[1]  = 1'b1;
                in_data[7:4] = 4'b1000;
                mode_ieee[1] = 1'b1;
            end
            if (k == 6) in_valid[1] = 1'b0;
            if (k == 10) begin
                in_data[7:4] = 4'b0111;
                mode_ieee    = 2'b00;
            end
        end
        check("indep_wave0", w0, {19'd0, 24'b000111000111000111111000, 5'd0});
        check("indep_wave1", w1, {19'd0, 5'd0, 24'b000111111000111000111000});
        check("indep_done0", d0, 48'd1 << 5);
        check("indep_done1", d1, 48'd1);
        mode_ieee = '0;

        // Reset in the middle of a frame
        send(0, 4'b1111, 1'b0);
        capture(0, 10, 0, w, a, d, r);
        check("pre_reset_wave", w, 48'b1110001110);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("post_reset_state", {43'd0, tx_line[0], tx_active[0], in_ready[0], frame_done}, 48'b00100);
        capture(0, 20, 0, w, a, d, r);
        check("post_reset_no_done", d, 48'd0);
        check("post_reset_quiet", w | a, 48'd0);
        run_frame(0, 4'b1010, 1'b1, 24'b000111111000000111111000);

        // Stall: no valid for 50 cycles
        bad_line = 1'b0; bad_ready = 1'b0; bad_done = 1'b0; bad_act = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            bad_line  |= |tx_line;
            bad_ready |= (in_ready != 2'b11);
            bad_done  |= |frame_done;
            bad_act   |= |tx_active;
        end
        check("stall_flags", {44'd0, bad_line, bad_ready, bad_done, bad_act}, 48'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
